// File: rtl/mux_scan_n_1.sv
// N:1 channel multiplexer with a one-deep registered output slot and valid/ready handshake.
// The channel is chosen by Select_In (manual) or by a round-robin scan pointer that dwells DWELL_CYCLES per channel.
module mux_scan_n_1 #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int SEL_WIDTH    = 2,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                               Clock_In,
    input  logic                               Reset_n_In,
    input  logic                               Enable_In,
    input  logic                               Mode_In,
    input  logic [SEL_WIDTH-1:0]               Select_In,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
    input  logic                               Ready_In,
    output logic [DATA_WIDTH-1:0]              Data_Out,
    output logic [SEL_WIDTH-1:0]               Channel_Out,
    output logic                               Valid_Out,
    output logic                               Select_Error_Out
);

    typedef enum logic [1:0] {
        DISABLED,
        MANUAL,
        SCAN_COUNT,
        SCAN_STALL
    } state_e;

    localparam int unsigned           NUM_CH_U   = NUM_CHANNELS;
    localparam logic [SEL_WIDTH-1:0]  LAST_CH    = SEL_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [15:0]           DWELL_LAST = 16'(DWELL_CYCLES - 1);

    logic [1:0]            rst_sync_q;
    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_WIDTH-1:0]  chan_q, chan_d;
    logic                  valid_q, valid_d;
    logic                  sel_err_q, sel_err_d;

    logic                  active;
    logic                  slot_free;
    logic                  sel_ok;
    logic                  cap;
    logic [SEL_WIDTH-1:0]  cap_ch;
    logic [SEL_WIDTH-1:0]  ptr_next;
    logic [DATA_WIDTH-1:0] cap_data;

    assign active    = rst_sync_q[1];
    assign slot_free = !valid_q || Ready_In;
    assign sel_ok    = 32'(Select_In) < NUM_CH_U;
    assign ptr_next  = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;

    always_comb begin
        cap_data = '0;
        for (int unsigned k = 0; k < NUM_CH_U; k++) begin
            if (32'(cap_ch) == k) begin
                cap_data = Data_In[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A cycle in which Mode_In disagrees with the current state only switches state; it never captures.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        chan_d    = chan_q;
        valid_d   = valid_q;
        sel_err_d = 1'b0;
        cap       = 1'b0;
        cap_ch    = ptr_q;

        if (!active || !Enable_In) begin
            state_d = DISABLED;
            ptr_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                DISABLED: begin
                    state_d = Mode_In ? SCAN_COUNT : MANUAL;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
                MANUAL: begin
                    if (Mode_In) begin
                        state_d = SCAN_COUNT;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end else if (sel_ok) begin
                        cap    = slot_free;
                        cap_ch = Select_In;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                SCAN_COUNT: begin
                    if (!Mode_In) begin
                        state_d = MANUAL;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end else if (cnt_q == DWELL_LAST) begin
                        if (slot_free) begin
                            cap   = 1'b1;
                            ptr_d = ptr_next;
                            cnt_d = '0;
                        end else begin
                            state_d = SCAN_STALL;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                SCAN_STALL: begin
                    if (!Mode_In) begin
                        state_d = MANUAL;
                        ptr_d   = '0;
                        cnt_d   = '0;
                    end else if (slot_free) begin
                        cap     = 1'b1;
                        ptr_d   = ptr_next;
                        cnt_d   = '0;
                        state_d = SCAN_COUNT;
                    end
                end
                default: state_d = DISABLED;
            endcase

            if (cap) begin
                data_d  = cap_data;
                chan_d  = cap_ch;
                valid_d = 1'b1;
            end else if (slot_free) begin
                valid_d = 1'b0;
            end
        end
    end

    // rst_sync_q keeps the controller parked in DISABLED for two edges after reset release.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            rst_sync_q <= '0;
            state_q    <= DISABLED;
            ptr_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            chan_q     <= '0;
            valid_q    <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            chan_q     <= chan_d;
            valid_q    <= valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign Data_Out         = data_q;
    assign Channel_Out      = chan_q;
    assign Valid_Out        = valid_q;
    assign Select_Error_Out = sel_err_q;

endmodule
